nn_output_argmax: RTL and testbench
===================================

// Module: nn_output_argmax
// PURPOSE
//  Classification stage directly downstream of the final-layer output register block.
//  - Consumes that block's a_tdata/a_tvalid stream of N_CLASSES signed final-layer scores per image.
//  - Finds the index of the largest score and presents {class, score} on a valid/ready result port.
//  - Keeps frame and error status for software polling.
// PARAMETERS
//  DATA_W     32  width of one score; two's-complement signed
//  N_CLASSES  10  number of scores per frame (one frame per image)
//  IDX_W      4   class index width; must satisfy 2**IDX_W >= N_CLASSES
//  CNT_W      16  width of the completed-frame counter
// PORTS
//  aclk         in   1          clock; all logic on rising edge
//  aresetn      in   1          synchronous active-low reset
//  s_tdata      in   DATA_W     score beat from the upstream output block
//  s_tvalid     in   1          beat valid; no tready, so every valid beat is accepted
//  s_tlast      in   1          last beat of frame; present only with NN_ARGMAX_TLAST_EN
//  clear        in   1          synchronous abort/clear, active high
//  m_class      out  IDX_W      index of the maximum score
//  m_score      out  DATA_W     value of the maximum score
//  m_valid      out  1          result valid
//  m_ready      in   1          result consumed when m_valid && m_ready
//  overflow     out  1          sticky: a result was overwritten before it was consumed
//  frame_err    out  1          sticky: malformed frame (TLAST_EN only, else 0)
//  frame_count  out  CNT_W      completed frames; wraps at 2**CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (aresetn==0 at a rising edge)
//   - All outputs and internal state go to 0; FSM goes to S_IDLE.
//   - A partial frame in progress is discarded.
//  FSM
//   - S_IDLE -> S_ACC on a beat: best<=data, best_idx<=0, idx<=1.
//   - S_ACC, each beat: if $signed(data) > $signed(best), load best<=data, best_idx<=idx; idx++.
//   - Comparison is strict, so ties keep the lowest index.
//   - Beat with idx==N_CLASSES-1 completes the frame: final compare includes that beat.
//     The FSM returns to S_IDLE and idx<=0.
//   - N_CLASSES==1: the first beat completes the frame.
//  Result
//   - Latency: m_valid rises on the edge after the last beat is accepted (1 cycle).
//   - m_class/m_score are stable while m_valid=1 and m_ready=0.
//   - m_valid falls on the edge after m_valid && m_ready.
//   - A new result that completes while m_valid=1 and not being consumed overwrites the
//     held result and sets overflow. m_valid stays 1.
//   - Completion in the same cycle as consumption is a normal handoff: no overflow.
//   - frame_count increments on every completed frame, including overwriting ones.
//  Back-to-back
//   - Beats on consecutive cycles across a frame boundary are accepted with no bubble.
//  clear
//   - Behaves as reset for the FSM, idx, m_valid, overflow and frame_err.
//   - frame_count is kept.
//   - clear has priority over a beat in the same cycle; that beat is dropped.
// CONFIGURATION
//  NN_ARGMAX_TLAST_EN defined
//   - The s_tlast port exists.
//   - s_tlast on a beat with idx<N_CLASSES-1: frame dropped, frame_err<=1, go to S_IDLE.
//   - idx==N_CLASSES-1 with s_tlast=0: frame dropped, frame_err<=1, go to S_DRAIN.
//     S_DRAIN discards beats up to and including the next s_tlast, then goes to S_IDLE.
//   - A dropped frame produces no result and does not count.
//  NN_ARGMAX_TLAST_EN undefined
//   - No s_tlast port and no S_DRAIN state.
//   - Frames are delimited by count only; frame_err is tied to 0.
// STRUCTURE
//  Shared package nn_pkg
//   - N_CLASSES_DEF=10, DATA_W_DEF=32.
//   - FSM state encodings: S_IDLE=2'd0, S_ACC=2'd1, S_DRAIN=2'd2.
//  Sub-module nn_argmax_cmp (combinational)
//   - Signed strict-greater compare-select of {best,best_idx} vs {data,idx}.
//   - Top level holds the FSM, counters and result register.
// TESTING
//  1. Scores 0x0000abcd,0x1111babe,...,0x8888cafe,0x9999dead on 10 consecutive cycles
//     -> 1 cycle later m_valid=1, m_class=7, m_score=0x7777babe, frame_count=1.
//  2. Ten beats all 0x00000005 -> m_class=0 (tie keeps lowest index).
//     Ten beats all negative with beat 3 = 0xffffffff as largest -> m_class=3.
//  3. m_ready held 0, two frames with maxima at index 2 then 9
//     -> overflow=1, m_class=9, frame_count=2.
//     Assert m_ready -> m_valid drops the next cycle.
//  4. Beats 0..4 sent, clear pulsed, then a full frame with max at index 4 sent
//     -> exactly one result with m_class=4 and overflow=0.
//     Repeat using aresetn instead of clear -> same result, frame_count=1.
//  5. TLAST_EN: s_tlast on beat 6 -> no result, frame_err=1.
//     12-beat frame with s_tlast on beat 11 -> no result, drained.
//     Next correct frame -> its result is valid.
//  6. Two frames back-to-back with no gap, m_ready=1
//     -> two results exactly 10 cycles apart, frame_count=2.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the nn output argmax slice: default sizes and the
// classification FSM state encodings.
package nn_pkg;

    localparam int N_CLASSES_DEF = 10;
    localparam int DATA_W_DEF    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/nn_argmax_cmp.sv
// Combinational compare-select for the argmax scan. The incoming beat replaces
// the running best only when it is strictly greater (signed), so ties keep the
// earlier, lower class index.
module nn_argmax_cmp
    import nn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = 4
) (
    input  logic [DATA_W-1:0] best,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] sel_score,
    output logic [IDX_W-1:0]  sel_idx
);

    // Pick the larger of the running best and the new beat, favouring the running best on ties.
    always_comb begin
        sel_score = best;
        sel_idx   = best_idx;
        if ($signed(data) > $signed(best)) begin
            sel_score = data;
            sel_idx   = idx;
        end
    end

endmodule

// File: rtl/nn_output_argmax.sv
// Classification stage after the final-layer output block: scans N_CLASSES
// signed scores per frame, reports the index and value of the largest on a
// valid/ready result port, and keeps overflow / frame error / frame count status.
// Optional feature macro: NN_ARGMAX_TLAST_EN adds the s_tlast port, frame
// framing checks and the S_DRAIN recovery state.
module nn_output_argmax
    import nn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
`ifdef NN_ARGMAX_TLAST_EN
    input  logic              s_tlast,
`endif
    input  logic              clear,
    output logic [IDX_W-1:0]  m_class,
    output logic [DATA_W-1:0] m_score,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overflow,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              m_valid_q, m_valid_d;
    logic [IDX_W-1:0]  m_class_q, m_class_d;
    logic [DATA_W-1:0] m_score_q, m_score_d;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;

    logic [DATA_W-1:0] sel_score;
    logic [IDX_W-1:0]  sel_idx;
    logic              done;
    logic [IDX_W-1:0]  done_class;
    logic [DATA_W-1:0] done_score;

    nn_argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .best      (best_q),
        .best_idx  (best_idx_q),
        .data      (s_tdata),
        .idx       (idx_q),
        .sel_score (sel_score),
        .sel_idx   (sel_idx)
    );

    // Next-state logic: frame scan FSM, result handoff, overflow and frame counting.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        m_valid_d     = m_valid_q;
        m_class_d     = m_class_q;
        m_score_d     = m_score_q;
        overflow_d    = overflow_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;
        done          = 1'b0;
        done_class    = sel_idx;
        done_score    = sel_score;

        if (clear) begin
            // Abort wins over any beat this cycle; the frame counter survives.
            state_d     = S_IDLE;
            idx_d       = '0;
            m_valid_d   = 1'b0;
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end else begin
            if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
            end

            if (s_tvalid) begin
                case (state_q)
                    S_IDLE: begin
                        if (N_CLASSES == 1) begin
`ifdef NN_ARGMAX_TLAST_EN
                            if (!s_tlast) begin
                                frame_err_d = 1'b1;
                                state_d     = S_DRAIN;
                            end else
`endif
                            begin
                                done       = 1'b1;
                                done_class = '0;
                                done_score = s_tdata;
                            end
                        end
`ifdef NN_ARGMAX_TLAST_EN
                        else if (s_tlast) begin
                            frame_err_d = 1'b1;
                        end
`endif
                        else begin
                            best_d     = s_tdata;
                            best_idx_d = '0;
                            idx_d      = IDX_W'(1);
                            state_d    = S_ACC;
                        end
                    end
                    S_ACC: begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
`ifdef NN_ARGMAX_TLAST_EN
                            if (!s_tlast) begin
                                frame_err_d = 1'b1;
                                state_d     = S_DRAIN;
                            end else
`endif
                            done = 1'b1;
                        end
`ifdef NN_ARGMAX_TLAST_EN
                        else if (s_tlast) begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                            idx_d       = '0;
                        end
`endif
                        else begin
                            best_d     = sel_score;
                            best_idx_d = sel_idx;
                            idx_d      = idx_q + 1'b1;
                        end
                    end
`ifdef NN_ARGMAX_TLAST_EN
                    S_DRAIN: begin
                        if (s_tlast) begin
                            state_d = S_IDLE;
                        end
                    end
`endif
                    default: begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                endcase
            end

            if (done) begin
                // A completion overwrites an unconsumed result; same-cycle consume is a clean handoff.
                m_valid_d     = 1'b1;
                m_class_d     = done_class;
                m_score_d     = done_score;
                frame_count_d = frame_count_q + 1'b1;
                if (m_valid_q && !m_ready) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            m_valid_q     <= 1'b0;
            m_class_q     <= '0;
            m_score_q     <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            m_valid_q     <= m_valid_d;
            m_class_q     <= m_class_d;
            m_score_q     <= m_score_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_class     = m_class_q;
    assign m_score     = m_score_q;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nn_output_argmax.sv
// Directed testbench for nn_output_argmax with hand-computed expectations.
// Framing checks run only when NN_ARGMAX_TLAST_EN is defined.
module tb_nn_output_argmax;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        clear;
    logic [3:0]  m_class;
    logic [31:0] m_score;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_count;

    int compareCount;
    int mismatchCount;
    int expCount;

    nn_output_argmax dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
`ifdef NN_ARGMAX_TLAST_EN
        .s_tlast     (s_tlast),
`endif
        .clear       (clear),
        .m_class     (m_class),
        .m_score     (m_score),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    // Free-running 10 ns clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one beat for one clock edge; sampling point is #1 after that edge.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        s_tdata  = data;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Send a 10-beat frame, tlast on the final beat.
    task automatic sendFrame(input logic [31:0] f [10]);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(f[i], i == 9);
        end
    endtask

    task automatic consumeResult();
        m_ready = 1'b1;
        @(posedge aclk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
    endtask

    task automatic pulseReset();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    logic [31:0] frame1 [10] = '{32'h0000abcd, 32'h1111babe, 32'h2222cafe, 32'h3333dead, 32'h4444abcd,
                                 32'h5555babe, 32'h6666cafe, 32'h7777babe, 32'h8888cafe, 32'h9999dead};
    logic [31:0] frameTie [10] = '{default: 32'h00000005};
    logic [31:0] frameNeg [10] = '{32'h80000000, 32'hfffffff0, 32'h80000001, 32'hffffffff, 32'hfffffffe,
                                   32'hc0000000, 32'hfffffffe, 32'h90000000, 32'hffff0000, 32'hfffffffd};
    logic [31:0] frameMax2 [10] = '{1, 2, 100, 3, 4, 5, 6, 7, 8, 9};
    logic [31:0] frameMax9 [10] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 1000};
    logic [31:0] frameMax4 [10] = '{1, 2, 3, 4, 500, 6, 7, 8, 9, 10};
    logic [31:0] frameMax3 [10] = '{7, 7, 7, 70, 7, 7, 7, 7, 7, 7};
    logic [31:0] frameMax8 [10] = '{32'hfffffff0, 1, 2, 3, 4, 5, 6, 7, 900, 8};

    int hitBeat [$];
    int hitClass [$];

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        aresetn  = 1'b0;
        clear    = 1'b0;
        m_ready  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_class", 64'(m_class), 64'd0);
        checkOutput("rst_m_score", 64'(m_score), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
        checkOutput("rst_frame_count", 64'(frame_count), 64'd0);

        $display("[TB] basic frame");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(frame1[i], i == 9);
            if (i == 8) checkOutput("t1_no_early_valid", 64'(m_valid), 64'd0);
        end
        checkOutput("t1_m_valid", 64'(m_valid), 64'd1);
        checkOutput("t1_m_class", 64'(m_class), 64'd7);
        checkOutput("t1_m_score", 64'(m_score), 64'h7777babe);
        checkOutput("t1_frame_count", 64'(frame_count), 64'd1);
        checkOutput("t1_overflow", 64'(overflow), 64'd0);
        consumeResult();
        checkOutput("t1_valid_drop", 64'(m_valid), 64'd0);

        $display("[TB] ties and negatives");
        sendFrame(frameTie);
        checkOutput("t2_tie_class", 64'(m_class), 64'd0);
        checkOutput("t2_tie_score", 64'(m_score), 64'd5);
        consumeResult();
        sendFrame(frameNeg);
        checkOutput("t2_neg_valid", 64'(m_valid), 64'd1);
        checkOutput("t2_neg_class", 64'(m_class), 64'd3);
        checkOutput("t2_neg_score", 64'(m_score), 64'hffffffff);
        checkOutput("t2_frame_count", 64'(frame_count), 64'd3);
        consumeResult();

        $display("[TB] overflow");
        sendFrame(frameMax2);
        checkOutput("t3_first_class", 64'(m_class), 64'd2);
        checkOutput("t3_first_overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("t3_hold_class", 64'(m_class), 64'd2);
        checkOutput("t3_hold_score", 64'(m_score), 64'd100);
        sendFrame(frameMax9);
        checkOutput("t3_overflow", 64'(overflow), 64'd1);
        checkOutput("t3_m_valid", 64'(m_valid), 64'd1);
        checkOutput("t3_m_class", 64'(m_class), 64'd9);
        checkOutput("t3_m_score", 64'(m_score), 64'd1000);
        checkOutput("t3_frame_count", 64'(frame_count), 64'd5);
        consumeResult();
        checkOutput("t3_valid_drop", 64'(m_valid), 64'd0);
        checkOutput("t3_overflow_sticky", 64'(overflow), 64'd1);
        pulseClear();
        checkOutput("t3_clear_overflow", 64'(overflow), 64'd0);
        checkOutput("t3_clear_keeps_count", 64'(frame_count), 64'd5);

        $display("[TB] abort by clear");
        applyStimulus(32'd9000, 1'b0);
        for (int i = 1; i < 5; i++) applyStimulus(32'd1, 1'b0);
        pulseClear();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(frameMax4[i], i == 9);
            if (i == 8) checkOutput("t4_clear_no_early", 64'(m_valid), 64'd0);
        end
        checkOutput("t4_clear_valid", 64'(m_valid), 64'd1);
        checkOutput("t4_clear_class", 64'(m_class), 64'd4);
        checkOutput("t4_clear_score", 64'(m_score), 64'd500);
        checkOutput("t4_clear_overflow", 64'(overflow), 64'd0);
        checkOutput("t4_clear_count", 64'(frame_count), 64'd6);
        consumeResult();

        $display("[TB] abort by reset");
        applyStimulus(32'd9000, 1'b0);
        for (int i = 1; i < 5; i++) applyStimulus(32'd1, 1'b0);
        pulseReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(frameMax4[i], i == 9);
            if (i == 8) checkOutput("t4_rst_no_early", 64'(m_valid), 64'd0);
        end
        checkOutput("t4_rst_valid", 64'(m_valid), 64'd1);
        checkOutput("t4_rst_class", 64'(m_class), 64'd4);
        checkOutput("t4_rst_overflow", 64'(overflow), 64'd0);
        checkOutput("t4_rst_count", 64'(frame_count), 64'd1);
        consumeResult();
        expCount = 1;

`ifdef NN_ARGMAX_TLAST_EN
        $display("[TB] framing errors");
        for (int i = 0; i < 7; i++) applyStimulus(32'(i + 1), i == 6);
        checkOutput("t5_short_valid", 64'(m_valid), 64'd0);
        checkOutput("t5_short_err", 64'(frame_err), 64'd1);
        checkOutput("t5_short_count", 64'(frame_count), 64'(expCount));
        for (int i = 0; i < 12; i++) applyStimulus(32'(i + 100), i == 11);
        checkOutput("t5_long_valid", 64'(m_valid), 64'd0);
        checkOutput("t5_long_count", 64'(frame_count), 64'(expCount));
        for (int i = 0; i < 10; i++) applyStimulus((i == 5) ? 32'd77 : 32'd3, i == 9);
        expCount++;
        checkOutput("t5_good_valid", 64'(m_valid), 64'd1);
        checkOutput("t5_good_class", 64'(m_class), 64'd5);
        checkOutput("t5_good_count", 64'(frame_count), 64'(expCount));
        checkOutput("t5_err_sticky", 64'(frame_err), 64'd1);
        consumeResult();
        pulseClear();
        checkOutput("t5_clear_err", 64'(frame_err), 64'd0);
`else
        checkOutput("t5_err_tied", 64'(frame_err), 64'd0);
`endif

        $display("[TB] back-to-back");
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i < 10) ? frameMax3[i] : frameMax8[i - 10], (i == 9) || (i == 19));
            if (m_valid) begin
                hitBeat.push_back(i);
                hitClass.push_back(int'(m_class));
            end
        end
        expCount += 2;
        checkOutput("t6_results", 64'(hitBeat.size()), 64'd2);
        if (hitBeat.size() == 2) begin
            checkOutput("t6_first_beat", 64'(hitBeat[0]), 64'd9);
            checkOutput("t6_spacing", 64'(hitBeat[1] - hitBeat[0]), 64'd10);
            checkOutput("t6_first_class", 64'(hitClass[0]), 64'd3);
            checkOutput("t6_second_class", 64'(hitClass[1]), 64'd8);
        end
        checkOutput("t6_frame_count", 64'(frame_count), 64'(expCount));
        checkOutput("t6_overflow", 64'(overflow), 64'd0);
        @(posedge aclk);
        #1;
        m_ready = 1'b0;
        checkOutput("t6_valid_drop", 64'(m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
